// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: function codes and FSM states.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu.
//   master: drives in_valid, a, b, F, out_ready; observes in_ready and the result.
//   slave : the ALU side, the mirror image.
interface seq_alu_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       F;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] Qhi;
   logic             Cout;
   logic             Zero;
   logic             Ovf;

   modport master (
      output in_valid, a, b, F, out_ready,
      input  in_ready, out_valid, Q, Qhi, Cout, Zero, Ovf
   );

   modport slave (
      input  in_valid, a, b, F, out_ready,
      output in_ready, out_valid, Q, Qhi, Cout, Zero, Ovf
   );
endinterface

// File: rtl/alu_comb.sv
// Combinational single-cycle ALU ops (everything except MUL) and their flags.
//   a, b : operands          f    : function code
//   q    : result            cout : carry / shift-out
//   zero : q == 0            ovf  : signed overflow for ADD/SUB
module alu_comb #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       f,
   output logic [WIDTH-1:0] q,
   output logic             cout,
   output logic             zero,
   output logic             ovf
);
   import alu_pkg::*;

   logic [WIDTH-1:0] bop;
   logic [WIDTH:0]   sum;
   logic             is_sub;

   always_comb begin
      q      = '0;
      cout   = 1'b0;
      ovf    = 1'b0;
      is_sub = (f == OP_SUB);
      // SUB reuses the adder as a + ~b + 1
      bop    = is_sub ? ~b : b;
      sum    = {1'b0, a} + {1'b0, bop} + {{WIDTH{1'b0}}, is_sub};
      case (f)
         OP_ADD, OP_SUB: begin
            q    = sum[WIDTH-1:0];
            cout = sum[WIDTH];
            ovf  = (a[WIDTH-1] == bop[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: q = a & b;
         OP_OR:  q = a | b;
         OP_XOR: q = a ^ b;
         OP_SHL: begin
            q    = {a[WIDTH-2:0], 1'b0};
            cout = a[WIDTH-1];
         end
         OP_SHR: begin
            q    = {1'b0, a[WIDTH-1:1]};
            cout = a[0];
         end
         default: ;  // MUL is handled by the sequential datapath
      endcase
   end

   assign zero = (q == '0);

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes on both sides and a WIDTH-cycle
// shift-add unsigned multiplier.
//   clk, reset : clock and synchronous active-high reset
//   bus        : seq_alu_if slave (operands, F, result, Qhi, flags, handshakes)
module seq_alu import alu_pkg::*; #(
   parameter int unsigned WIDTH = 8
) (
   input  logic   clk,
   input  logic   reset,
   seq_alu_if.slave bus
);
   localparam int unsigned CNTW = $clog2(WIDTH + 1);

   state_t           state_q, state_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mlo_q, mlo_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] qhi_q, qhi_d;
   logic             cout_q, cout_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic             valid_q, valid_d;

   logic [WIDTH-1:0] c_q;
   logic             c_cout, c_zero, c_ovf;
   logic [WIDTH:0]   step_sum;
   logic [WIDTH-1:0] step_acc, step_lo;
   logic             in_ready;
   logic             accept;

   alu_comb #(.WIDTH(WIDTH)) u_comb (
      .a    (bus.a),
      .b    (bus.b),
      .f    (bus.F),
      .q    (c_q),
      .cout (c_cout),
      .zero (c_zero),
      .ovf  (c_ovf)
   );

   assign in_ready = !reset &&
                     ((state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready));
   assign accept   = bus.in_valid && in_ready;

   // One shift-add step: {acc, mlo} holds the partial product; the multiplier
   // drains out of the bottom of mlo as product bits shift in from acc.
   always_comb begin
      step_sum = {1'b0, acc_q} + (mlo_q[0] ? {1'b0, mcand_q} : '0);
      step_acc = step_sum[WIDTH:1];
      step_lo  = {step_sum[0], mlo_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mcand_d = mcand_q;
      mlo_d   = mlo_q;
      acc_d   = acc_q;
      q_d     = q_q;
      qhi_d   = qhi_q;
      cout_d  = cout_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      valid_d = valid_q;

      case (state_q)
         ST_MUL: begin
            acc_d = step_acc;
            mlo_d = step_lo;
            cnt_d = cnt_q + CNTW'(1);
            if (cnt_q == CNTW'(WIDTH - 1)) begin
               q_d     = step_lo;
               qhi_d   = step_acc;
               cout_d  = |step_acc;
               ovf_d   = |step_acc;
               zero_d  = (step_lo == '0);
               valid_d = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: ;
         default: state_d = ST_IDLE;
      endcase

      // A new operation overrides the idle/consume decisions above; this also
      // covers the same-edge handoff out of DONE.
      if (accept) begin
         if (bus.F == OP_MUL) begin
            mcand_d = bus.a;
            mlo_d   = bus.b;
            acc_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
            state_d = ST_MUL;
         end else begin
            q_d     = c_q;
            qhi_d   = '0;
            cout_d  = c_cout;
            zero_d  = c_zero;
            ovf_d   = c_ovf;
            valid_d = 1'b1;
            state_d = ST_DONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         mcand_q <= '0;
         mlo_q   <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         qhi_q   <= '0;
         cout_q  <= 1'b0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mcand_q <= mcand_d;
         mlo_q   <= mlo_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         qhi_q   <= qhi_d;
         cout_q  <= cout_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = valid_q;
   assign bus.Q         = q_q;
   assign bus.Qhi       = qhi_q;
   assign bus.Cout      = cout_q;
   assign bus.Zero      = zero_q;
   assign bus.Ovf       = ovf_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: one 8-bit and one 16-bit instance.
module tb_seq_alu;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   passed = 0;
   int   lat;
   int   busy;

   seq_alu_if #(.WIDTH(8))  bus8 ();
   seq_alu_if #(.WIDTH(16)) bus16 ();

   seq_alu #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus8)
   );

   seq_alu #(.WIDTH(16)) dut16 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus16)
   );

   always #5 clk = ~clk;

   logic [7:0] exp_q [7] = '{8'hA3, 8'h37, 8'h24, 8'h7F, 8'h5B, 8'hDA, 8'h36};
   logic       exp_c [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic       exp_v [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_zero8(input string tag);
      chk(tag, {11'd0, bus8.Q, bus8.Qhi, bus8.Cout, bus8.Zero, bus8.Ovf,
                bus8.out_valid, bus8.in_ready}, 32'd0);
   endtask

   // Present an op and return #1 after its accepting edge.
   task automatic issue8(input logic [2:0] f, input logic [7:0] av, input logic [7:0] bv);
      int n;
      bus8.in_valid = 1'b1;
      bus8.F = f;
      bus8.a = av;
      bus8.b = bv;
      n = 0;
      while (!bus8.in_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("accept8", {31'd0, bus8.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      bus8.in_valid = 1'b0;
   endtask

   task automatic issue16(input logic [2:0] f, input logic [15:0] av, input logic [15:0] bv);
      int n;
      bus16.in_valid = 1'b1;
      bus16.F = f;
      bus16.a = av;
      bus16.b = bv;
      n = 0;
      while (!bus16.in_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("accept16", {31'd0, bus16.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      bus16.in_valid = 1'b0;
   endtask

   // Latency 1 = result visible right after the accepting edge.
   task automatic wait8(output int l, output int nb);
      l = 1;
      nb = 0;
      while (!bus8.out_valid && l < 40) begin
         if (!bus8.in_ready) nb++;
         @(posedge clk);
         #1;
         l++;
      end
   endtask

   task automatic wait16(output int l);
      l = 1;
      while (!bus16.out_valid && l < 40) begin
         @(posedge clk);
         #1;
         l++;
      end
   endtask

   initial begin
      bus8.in_valid = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.F = '0;  bus8.out_ready = 1'b1;
      bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.F = '0; bus16.out_ready = 1'b1;

      // Reset held two cycles
      @(posedge clk); #1;
      chk_zero8("rst_cycle1");
      @(posedge clk); #1;
      chk_zero8("rst_cycle2");
      chk("rst16", {bus16.Q, bus16.Qhi[13:0], bus16.out_valid, bus16.in_ready}, 32'd0);
      reset = 1'b0;
      #1;
      chk("ready_after_rst", {30'd0, bus8.in_ready, bus16.in_ready}, 32'd3);

      // Single-cycle op sweep, a=0x6D b=0x36
      for (int i = 0; i < 7; i++) begin
         issue8(3'(i), 8'h6D, 8'h36);
         wait8(lat, busy);
         chk($sformatf("op%0d_lat", i), lat, 32'd1);
         chk($sformatf("op%0d_q", i), {24'd0, bus8.Q}, {24'd0, exp_q[i]});
         chk($sformatf("op%0d_flags", i), {28'd0, bus8.Cout, bus8.Ovf, bus8.Zero, bus8.out_valid},
             {28'd0, exp_c[i], exp_v[i], 1'b0, 1'b1});
         chk($sformatf("op%0d_qhi", i), {24'd0, bus8.Qhi}, 32'd0);
      end

      // MUL 0x6D*0x36 = 0x16FE
      issue8(3'b111, 8'h6D, 8'h36);
      wait8(lat, busy);
      chk("mul8_lat", lat, 32'd9);
      chk("mul8_busy", busy, 32'd8);
      chk("mul8_prod", {16'd0, bus8.Qhi, bus8.Q}, 32'h16FE);
      chk("mul8_flags", {29'd0, bus8.Cout, bus8.Ovf, bus8.Zero}, 32'b110);

      // ADD 0x80+0x80 held under backpressure
      issue8(3'b000, 8'h80, 8'h80);
      bus8.out_ready = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("hold%0d_q", i), {24'd0, bus8.Q}, 32'd0);
         chk($sformatf("hold%0d_st", i),
             {27'd0, bus8.Cout, bus8.Zero, bus8.Ovf, bus8.out_valid, bus8.in_ready}, 32'b11110);
         @(posedge clk); #1;
      end

      // Same-edge handoff with XOR
      bus8.out_ready = 1'b1;
      issue8(3'b100, 8'hFF, 8'h0F);
      chk("handoff_q", {24'd0, bus8.Q}, 32'h0F0);
      chk("handoff_valid", {31'd0, bus8.out_valid}, 32'd1);

      // Reset in the 4th MUL cycle
      issue8(3'b111, 8'h12, 8'h34);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      chk_zero8("mid_mul_rst");
      reset = 1'b0;
      #1;
      chk("idle_after_mid_rst", {31'd0, bus8.in_ready}, 32'd1);
      issue8(3'b000, 8'h01, 8'h01);
      wait8(lat, busy);
      chk("add_after_rst", {23'd0, bus8.out_valid, bus8.Q}, 32'h102);

      // 16-bit instance
      issue16(3'b000, 16'hFFFF, 16'h0001);
      wait16(lat);
      chk("add16_lat", lat, 32'd1);
      chk("add16", {13'd0, bus16.Cout, bus16.Zero, bus16.Ovf, bus16.Q}, {13'd0, 3'b110, 16'h0000});
      issue16(3'b111, 16'hFFFF, 16'hFFFF);
      wait16(lat);
      chk("mul16_lat", lat, 32'd17);
      chk("mul16_prod", {bus16.Qhi, bus16.Q}, 32'hFFFE0001);
      chk("mul16_flags", {29'd0, bus16.Cout, bus16.Ovf, bus16.Zero}, 32'b110);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
